// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared constants and types for the data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int c_MEM_WORDS = 1024;
    localparam int c_LOG_DEPTH = 8;
    localparam int c_LOG_W     = 96;

    typedef enum logic [1:0] {
        ST_WORD = 2'b00,
        ST_HALF = 2'b01,
        ST_BYTE = 2'b10,
        ST_RSVD = 2'b11
    } store_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

endpackage : dm_pkg
`default_nettype wire

// File: rtl/log_fifo.sv
`default_nettype none
// ============================================================================
// Module      : log_fifo
// Description : Synchronous FIFO holding store-log entries; push is accepted
//               when full only if a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module log_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int             c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0] c_ONE  = (c_PTR_W + 1)'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rptr];

    assign w_pop  = i_pop & ~o_empty;
    // A pop on the same edge frees the slot, so a full FIFO can still take a push.
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

endmodule : log_fifo
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-organised data memory with byte/half/word stores,
//               asynchronous reads and a FIFO log of every committed store.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int MEM_WORDS = c_MEM_WORDS,
    parameter int LOG_DEPTH = c_LOG_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic [1:0]  store_type,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow
);

    localparam int c_IDX_W = $clog2(MEM_WORDS);

    logic [31:0]        r_mem [MEM_WORDS];
    logic               r_overflow;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_old;
    logic [31:0]        w_merged;
    store_type_e        w_st;
    log_entry_t         w_push_entry;
    log_entry_t         w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    assign w_idx = addr[c_IDX_W+1:2];
    assign w_old = r_mem[w_idx];
    assign w_st  = store_type_e'(store_type);
    assign rdata = w_old;

    always_comb begin
        w_merged = w_old;
        case (w_st)
            ST_HALF: begin
                if (addr[1]) w_merged[31:16] = wdata[15:0];
                else         w_merged[15:0]  = wdata[15:0];
            end
            ST_BYTE: w_merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            default: w_merged = wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (mem_write) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign w_push = mem_write & ~reset;
    assign w_pop  = log_ready & ~w_empty;

    assign w_push_entry.pc   = pc;
    assign w_push_entry.addr = {addr[31:2], 2'b00};
    assign w_push_entry.data = w_merged;

    log_fifo #(
        .WIDTH (c_LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sticky until reset: set only when a push finds no room this edge.
    always_ff @(posedge clk) begin
        if (reset) r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end

    assign log_valid    = ~w_empty;
    assign log_pc       = w_head.pc;
    assign log_addr     = w_head.addr;
    assign log_data     = w_head.data;
    assign log_overflow = r_overflow;

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [1:0]  store_type;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_pc;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .wdata        (wdata),
        .mem_write    (mem_write),
        .store_type   (store_type),
        .pc           (pc),
        .rdata        (rdata),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_pc       (log_pc),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_overflow (log_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] p, input logic [1:0] st);
        addr = a; wdata = d; pc = p; store_type = st; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        addr = 32'h10; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata_10 got %h want %h", rdata, 32'h0); end
        addr = 32'hFFC; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata_ffc got %h want %h", rdata, 32'h0); end
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++; $display("FAIL reset_log_valid got %b want 0", log_valid); end
        n_cmp++; if (log_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", log_overflow); end
    endtask

    task automatic test_word_store();
        do_store(32'h10, 32'hDEADBEEF, 32'h3010, 2'b00);
        addr = 32'h10; #1;
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rdata got %h want %h", rdata, 32'hDEADBEEF); end
        n_cmp++; if (log_valid !== 1'b1) begin n_bad++; $display("FAIL word_log_valid got %b want 1", log_valid); end
        n_cmp++; if (log_pc !== 32'h3010) begin n_bad++; $display("FAIL word_log_pc got %h want %h", log_pc, 32'h3010); end
        n_cmp++; if (log_addr !== 32'h10) begin n_bad++; $display("FAIL word_log_addr got %h want %h", log_addr, 32'h10); end
        n_cmp++; if (log_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_log_data got %h want %h", log_data, 32'hDEADBEEF); end
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++; $display("FAIL word_pop_empty got %b want 0", log_valid); end
    endtask

    task automatic test_merge();
        logic [31:0] e_pc   [5];
        logic [31:0] e_addr [5];
        logic [31:0] e_data [5];
        e_pc[0] = 32'h100; e_addr[0] = 32'h20; e_data[0] = 32'h11223344;
        e_pc[1] = 32'h104; e_addr[1] = 32'h20; e_data[1] = 32'h11AA3344;
        e_pc[2] = 32'h108; e_addr[2] = 32'h20; e_data[2] = 32'h11AABEEF;
        e_pc[3] = 32'h10C; e_addr[3] = 32'h20; e_data[3] = 32'h5566BEEF;
        e_pc[4] = 32'h110; e_addr[4] = 32'h30; e_data[4] = 32'hCAFEF00D;
        do_store(32'h20, 32'h11223344, 32'h100, 2'b00);
        do_store(32'h22, 32'hFFFF00AA, 32'h104, 2'b10);
        do_store(32'h20, 32'hFFFFBEEF, 32'h108, 2'b01);
        addr = 32'hFFFFF020; #1;
        n_cmp++; if (rdata !== 32'h11AABEEF) begin n_bad++; $display("FAIL merge_sb_sh got %h want %h", rdata, 32'h11AABEEF); end
        do_store(32'h23, 32'h00005566, 32'h10C, 2'b01);
        do_store(32'h31, 32'hCAFEF00D, 32'h110, 2'b11);
        addr = 32'h20; #1;
        n_cmp++; if (rdata !== 32'h5566BEEF) begin n_bad++; $display("FAIL merge_sh_upper got %h want %h", rdata, 32'h5566BEEF); end
        addr = 32'h30; #1;
        n_cmp++; if (rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL merge_type11_word got %h want %h", rdata, 32'hCAFEF00D); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (log_valid !== 1'b1) begin n_bad++; $display("FAIL merge_log_valid[%0d] got %b want 1", i, log_valid); end
            n_cmp++; if (log_pc !== e_pc[i]) begin n_bad++; $display("FAIL merge_log_pc[%0d] got %h want %h", i, log_pc, e_pc[i]); end
            n_cmp++; if (log_addr !== e_addr[i]) begin n_bad++; $display("FAIL merge_log_addr[%0d] got %h want %h", i, log_addr, e_addr[i]); end
            n_cmp++; if (log_data !== e_data[i]) begin n_bad++; $display("FAIL merge_log_data[%0d] got %h want %h", i, log_data, e_data[i]); end
            log_ready = 1'b1;
            tick();
            log_ready = 1'b0;
        end
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++; $display("FAIL merge_drained got %b want 0", log_valid); end
    endtask

    task automatic test_overflow();
        log_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_store(32'h40 + 4 * i, 32'hA000 + i, 32'h2000 + 4 * i, 2'b00);
        end
        n_cmp++; if (log_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", log_overflow); end
        addr = 32'h60; #1;
        n_cmp++; if (rdata !== 32'hA008) begin n_bad++; $display("FAIL ovf_mem_still_written got %h want %h", rdata, 32'hA008); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (log_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_log_valid[%0d] got %b want 1", i, log_valid); end
            n_cmp++; if (log_pc !== 32'h2000 + 4 * i) begin n_bad++; $display("FAIL ovf_log_pc[%0d] got %h want %h", i, log_pc, 32'h2000 + 4 * i); end
            n_cmp++; if (log_data !== 32'hA000 + i) begin n_bad++; $display("FAIL ovf_log_data[%0d] got %h want %h", i, log_data, 32'hA000 + i); end
            log_ready = 1'b1;
            tick();
            log_ready = 1'b0;
        end
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained got %b want 0", log_valid); end
        n_cmp++; if (log_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", log_overflow); end
    endtask

    task automatic test_full_push_pop();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (log_overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf_cleared got %b want 0", log_overflow); end
        log_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_store(32'h100 + 4 * i, 32'hB000 + i, 32'h4000 + 4 * i, 2'b00);
        end
        n_cmp++; if (log_overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf_at_full got %b want 0", log_overflow); end
        log_ready = 1'b1;
        do_store(32'h120, 32'hB008, 32'h4020, 2'b00);
        log_ready = 1'b0;
        n_cmp++; if (log_overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_no_drop got %b want 0", log_overflow); end
        for (int i = 1; i < 9; i++) begin
            n_cmp++; if (log_valid !== 1'b1) begin n_bad++; $display("FAIL fpp_log_valid[%0d] got %b want 1", i, log_valid); end
            n_cmp++; if (log_pc !== 32'h4000 + 4 * i) begin n_bad++; $display("FAIL fpp_log_pc[%0d] got %h want %h", i, log_pc, 32'h4000 + 4 * i); end
            n_cmp++; if (log_data !== 32'hB000 + i) begin n_bad++; $display("FAIL fpp_log_data[%0d] got %h want %h", i, log_data, 32'hB000 + i); end
            log_ready = 1'b1;
            tick();
            log_ready = 1'b0;
        end
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_count8 got %b want 0", log_valid); end
    endtask

    task automatic test_read_during_write();
        addr = 32'h80; wdata = 32'h5; pc = 32'h500; store_type = 2'b00; mem_write = 1'b1;
        #1;
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rdw_old got %h want %h", rdata, 32'h0); end
        tick();
        mem_write = 1'b0;
        n_cmp++; if (rdata !== 32'h5) begin n_bad++; $display("FAIL rdw_new got %h want %h", rdata, 32'h5); end
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        log_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_store(32'h40 + 4 * i, 32'hC000 + i, 32'h6000 + 4 * i, 2'b00);
        end
        n_cmp++; if (log_overflow !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre_ovf got %b want 1", log_overflow); end
        addr = 32'h90; wdata = 32'h77; pc = 32'h7000; store_type = 2'b00; mem_write = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; mem_write = 1'b0;
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b want 0", log_valid); end
        n_cmp++; if (log_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ovf got %b want 0", log_overflow); end
        addr = 32'h90; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mid_store_dropped got %h want %h", rdata, 32'h0); end
        addr = 32'h40; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mid_mem_cleared got %h want %h", rdata, 32'h0); end
        tick();
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_not_logged got %b want 0", log_valid); end
    endtask

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; mem_write = 1'b0;
        store_type = 2'b00; pc = '0; log_ready = 1'b0;
        tick();
        tick();
        test_reset();
        test_word_store();
        test_merge();
        test_overflow();
        test_full_push_pop();
        test_read_during_write();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, 1024, number of 32-bit words; index = addr[11:2].
REQ-002 Parameter LOG_DEPTH, 8, write-log FIFO entries (power of 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 addr  input  32  byte address from core ALU; bits [31:12] ignored.
REQ-006 wdata  input  32  store data (rt value) from core.
REQ-007 mem_write  input  1  store request this cycle.
REQ-008 store_type  input  2  00 word, 01 half, 10 byte, 11 treated as word.
REQ-009 pc  input  32  PC of current instruction, captured into log.
REQ-010 rdata  output  32  load data, combinational from mem[addr[11:2]].
REQ-011 log_valid  output  1  log FIFO non-empty.
REQ-012 log_ready  input  1  consumer accepts head entry when log_valid high.
REQ-013 log_pc / log_addr / log_data  output  32 each  head entry: store PC, word-aligned byte address, full word after merge.
REQ-014 log_overflow  output  1  sticky: an entry was dropped.

Function
REQ-015 Read is asynchronous; rdata reflects memory contents before the current edge, so read-during-write returns old data that cycle.
REQ-016 Write occurs at rising edge when mem_write=1 and reset=0.
REQ-017 Word store: addr[1:0] ignored; whole word replaced.
REQ-018 Half store: addr[0] ignored; addr[1]=0 writes bits[15:0], addr[1]=1 writes bits[31:16] with wdata[15:0]; other half kept.
REQ-019 Byte store: addr[1:0]=n writes bits[8n+7:8n] with wdata[7:0]; little-endian; other bytes kept.
REQ-020 Each write pushes one log entry {pc, {addr[31:2],2'b00}, merged word} in the same edge; latency to log_valid = 1 cycle.
REQ-021 Pop when log_valid && log_ready at edge; entries leave in push order.
REQ-022 Full FIFO with simultaneous push and pop: both occur, count unchanged, no drop.
REQ-023 Full FIFO with push and no pop: new entry dropped, existing entries intact, log_overflow set to 1 and held until reset.
REQ-024 Empty FIFO: log_valid=0, log_ready ignored, log_* outputs hold last head value (don't-care for checking).
REQ-025 FIFO pointers wrap modulo LOG_DEPTH; occupancy counter width log2(LOG_DEPTH)+1.
REQ-026 Consecutive stores to same word: second merge uses result of first.

Reset
REQ-027 reset at edge clears all MEM_WORDS words to 0, empties FIFO (log_valid=0), clears log_overflow; any same-cycle store is discarded and not logged.
REQ-028 After reset, rdata=0 for every address; reset asserted mid-stream drops unread log entries.

Structure
REQ-029 Package dm_pkg holds MEM_WORDS, LOG_DEPTH defaults and store_type encodings ST_WORD, ST_HALF, ST_BYTE.
REQ-030 Byte-merge logic is combinational in the top; log FIFO is sub-module log_fifo (width 96, depth LOG_DEPTH, push/pop/full/empty).

Verification
REQ-031 Reset, then word store addr=0x10 wdata=0xDEADBEEF pc=0x3010 -> next cycle rdata@0x10=0xDEADBEEF; log = {0x3010, 0x10, 0xDEADBEEF}.
REQ-032 Preload 0x11223344 @0x20; sb addr=0x22 wdata=0xAA -> word 0x11AA3344; sh addr=0x20 wdata=0xBEEF -> 0x11AABEEF; two logs in order.
REQ-033 log_ready=0, 9 stores -> 8 entries retained, log_overflow=1; then drain -> first 8 in order, overflow stays 1.
REQ-034 FIFO full, store with log_ready=1 -> no drop, log_overflow=0, count stays 8.
REQ-035 Store and load same address same cycle (old 0x0, new 0x5) -> rdata=0x0 that cycle, 0x5 next.
REQ-036 Entries pending plus store during reset=1 -> after edge log_valid=0, rdata@store addr=0, overflow=0.
